// File: rtl/aes_key_streamer.sv
// Loads a KEY_WORDS-word AES key from an upstream stream and replays it
// block_count times into the AES engine key port, optionally reusing the stored key.
module aes_key_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WORDS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic                  reuse_key_i,
  input  logic [CNT_WIDTH-1:0]  block_count_i,
  input  logic                  key_in_valid_i,
  output logic                  key_in_ready_o,
  input  logic [DATA_WIDTH-1:0] key_in_data_i,
  output logic                  key_out_valid_o,
  input  logic                  key_out_ready_i,
  output logic [DATA_WIDTH-1:0] key_out_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  key_loaded_o,
  output logic [1:0]            state_dbg_o
);

  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a stalled word holds until accepted.

  localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]                       rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0]                   remaining_q, remaining_d;
  logic                                   key_loaded_q, key_loaded_d;
  logic [KEY_WORDS-1:0][DATA_WIDTH-1:0]   key_reg_q, key_reg_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      remaining_q  <= '0;
      key_loaded_q <= 1'b0;
      key_reg_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      remaining_q  <= remaining_d;
      key_loaded_q <= key_loaded_d;
      key_reg_q    <= key_reg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    remaining_d  = remaining_q;
    key_loaded_d = key_loaded_q;
    key_reg_d    = key_reg_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          remaining_d = block_count_i;
          wr_idx_d    = '0;
          rd_idx_d    = '0;
          if (block_count_i == '0)
            state_d = S_DONE;
          else if (reuse_key_i && key_loaded_q)
            state_d = S_STREAM;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (key_in_valid_i) begin
          key_reg_d[wr_idx_q] = key_in_data_i;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d     = '0;
            key_loaded_d = 1'b1;
            state_d      = S_STREAM;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (key_out_ready_i) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d    = '0;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CNT_WIDTH'(1))
              state_d = S_DONE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Soft clear overrides any start or handshake seen in the same cycle.
    if (clear_i) begin
      state_d      = S_IDLE;
      wr_idx_d     = '0;
      rd_idx_d     = '0;
      remaining_d  = '0;
      key_loaded_d = 1'b0;
      key_reg_d    = '0;
    end
  end

  assign key_in_ready_o  = (state_q == S_LOAD);
  assign key_out_valid_o = (state_q == S_STREAM);
  assign key_out_data_o  = (state_q == S_STREAM) ? key_reg_q[rd_idx_q] : '0;
  assign busy_o          = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign done_o          = (state_q == S_DONE);
  assign key_loaded_o    = key_loaded_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_aes_key_streamer.sv
// Directed plus randomized jobs for aes_key_streamer, checked against a
// job-level model: expected output word list, expected load path, done timing.
module tb_aes_key_streamer;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic          reuse_key_i = 1'b0;
  logic [CW-1:0] block_count_i = '0;
  logic          key_in_valid_i = 1'b0;
  logic          key_in_ready_o;
  logic [DW-1:0] key_in_data_i = '0;
  logic          key_out_valid_o;
  logic          key_out_ready_i = 1'b0;
  logic [DW-1:0] key_out_data_o;
  logic          busy_o, done_o, key_loaded_o;
  logic [1:0]    state_dbg_o;

  aes_key_streamer #(.DATA_WIDTH(DW), .KEY_WORDS(KW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .reuse_key_i(reuse_key_i), .block_count_i(block_count_i),
    .key_in_valid_i(key_in_valid_i), .key_in_ready_o(key_in_ready_o),
    .key_in_data_i(key_in_data_i), .key_out_valid_o(key_out_valid_o),
    .key_out_ready_i(key_out_ready_i), .key_out_data_o(key_out_data_o),
    .busy_o(busy_o), .done_o(done_o), .key_loaded_o(key_loaded_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] model_key[KW];
  logic [DW-1:0] next_key[KW];
  bit            model_loaded = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     busy_o, 0);
    check({tag, "_done"},     done_o, 0);
    check({tag, "_in_ready"}, key_in_ready_o, 0);
    check({tag, "_out_valid"}, key_out_valid_o, 0);
    check({tag, "_out_data"}, key_out_data_o, 0);
    check({tag, "_loaded"},   key_loaded_o, 0);
  endtask

  // ---------------- driver ----------------
  // mode: 0 ready always 1, 1 ready pattern 1,0,0,1, 2 random valid/ready/start.
  // abort_kind: 0 none, 1 clear after abort_at output words, 2 reset after abort_at key words.
  task automatic run_job(input int count, input bit reuse, input int mode,
                         input int abort_kind, input int abort_at);
    bit exp_load, aborted, finished;
    int it, n_in, n_out, n_out_before, n_ready, last_load, first_valid;
    bit stalled;

    exp_load = (count != 0) && !(reuse && model_loaded);
    in_q.delete();
    exp_q.delete();
    if (exp_load)
      for (int k = 0; k < KW; k++) in_q.push_back(next_key[k]);
    for (int b = 0; b < count; b++)
      for (int k = 0; k < KW; k++)
        exp_q.push_back(exp_load ? next_key[k] : model_key[k]);

    @(negedge clk_i);
    start_i         = 1'b1;
    block_count_i   = CW'(count);
    reuse_key_i     = reuse;
    key_in_valid_i  = 1'b0;
    key_out_ready_i = 1'b0;

    it = 0; n_in = 0; n_out = 0; n_ready = 0;
    last_load = -1; first_valid = -1;
    stalled = 1'b0; aborted = 1'b0; finished = 1'b0;

    while (!finished && !aborted && it < 3000) begin
      it++;
      @(negedge clk_i);
      start_i        = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      key_in_valid_i = (in_q.size() > 0) && (mode != 2 || $urandom_range(0, 1) == 1);
      key_in_data_i  = (in_q.size() > 0) ? in_q[0] : $urandom;
      case (mode)
        0:       key_out_ready_i = 1'b1;
        1:       key_out_ready_i = ((it - 1) % 4 == 0) || ((it - 1) % 4 == 3);
        default: key_out_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      n_out_before = n_out;
      check("busy", busy_o, (n_out_before < KW * count) ? 1 : 0);
      check("done", done_o, (n_out_before == KW * count) ? 1 : 0);
      if (n_out_before == KW * count) finished = 1'b1;

      if (key_in_ready_o) n_ready++;
      if (key_in_ready_o && key_in_valid_i) begin
        n_in++;
        last_load = it;
        if (in_q.size() > 0) void'(in_q.pop_front());
      end

      if (stalled) check("valid_held", key_out_valid_o, 1);
      stalled = 1'b0;
      if (key_out_valid_o) begin
        if (first_valid < 0) first_valid = it;
        if (exp_q.size() == 0) begin
          check("extra_word", key_out_valid_o, 0);
        end else begin
          check("out_data", key_out_data_o, exp_q[0]);
          if (key_out_ready_i) begin
            void'(exp_q.pop_front());
            n_out++;
          end else begin
            stalled = 1'b1;
          end
        end
      end

      if ((abort_kind == 1 && n_out == abort_at && n_out_before != n_out) ||
          (abort_kind == 2 && n_in == abort_at && key_in_ready_o && key_in_valid_i))
        aborted = 1'b1;
    end

    if (aborted) begin
      @(negedge clk_i);
      start_i = 1'b0; key_in_valid_i = 1'b0; key_out_ready_i = 1'b0;
      if (abort_kind == 1) clear_i = 1'b1;
      else rst_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      rst_i   = 1'b0;
      #1;
      check_idle_outputs(abort_kind == 1 ? "clear" : "reset");
      model_loaded = 1'b0;
      repeat (3) begin
        @(negedge clk_i);
        #1;
        check("no_done_after_abort", done_o, 0);
      end
      return;
    end

    check("job_words_out", n_out, KW * count);
    check("key_words_in", n_in, exp_load ? KW : 0);
    if (!exp_load) check("no_key_in_ready", n_ready, 0);
    if (count > 0)
      check("first_valid_cycle", first_valid, exp_load ? last_load + 1 : 1);
    check("key_loaded", key_loaded_o, (model_loaded || exp_load) ? 1 : 0);
    if (exp_load) begin
      for (int k = 0; k < KW; k++) model_key[k] = next_key[k];
      model_loaded = 1'b1;
    end

    @(negedge clk_i);
    start_i = 1'b0; key_in_valid_i = 1'b0; key_out_ready_i = 1'b0;
    #1;
    check("done_one_cycle", done_o, 0);
    check("idle_not_busy", busy_o, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < KW; k++) model_key[k] = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_idle_outputs("por");

    // Basic job with the FIPS-197 example key, two blocks.
    next_key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    run_job(2, 1'b0, 0, 0, 0);

    // Reuse stored key, three blocks.
    run_job(3, 1'b1, 0, 0, 0);

    // Backpressure 1,0,0,1 on the output stream.
    run_job(2, 1'b1, 1, 0, 0);

    // Zero block count.
    run_job(0, 1'b0, 0, 0, 0);

    // Randomized jobs: fresh key, then reuse of it.
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < KW; k++) next_key[k] = $urandom;
      run_job($urandom_range(1, 5), j[0], 2, 0, 0);
    end

    // Clear after the 5th output word of a 4-block job, then reuse must reload.
    run_job(4, 1'b1, 0, 1, 5);
    for (int k = 0; k < KW; k++) next_key[k] = $urandom;
    run_job(1, 1'b1, 0, 0, 0);

    // Reset after two key words, then reload with 0..3 (reuse requested but no key).
    for (int k = 0; k < KW; k++) next_key[k] = $urandom;
    run_job(2, 1'b0, 0, 2, 2);
    next_key = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h00000003};
    run_job(1, 1'b1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
